// File: rtl/txt_pkg.sv
// ---------------------------------------------------------------------------
// txt_pkg
// Shared constants and helpers for the text-mode renderer:
//   - default font and screen geometry
//   - character-memory word layout (7-bit glyph code plus an inverse bit)
//   - raster event type used by the glyph raster counters
//   - COLS / ROWS derivation (integer division of screen by glyph size)
// ---------------------------------------------------------------------------
package txt_pkg;

    localparam int DEF_FONT_W       = 15;
    localparam int DEF_FONT_H       = 21;
    localparam int DEF_SCREEN_W     = 640;
    localparam int DEF_SCREEN_H     = 480;
    localparam int DEF_ADDR_W       = 13;
    localparam int DEF_BLINK_FRAMES = 30;

    // Character-memory word: bits [6:0] glyph code, bit 7 inverse video
    localparam int DEF_CHAR_W = 8;
    localparam int INV_BIT    = 7;
    localparam int CODE_MSB   = 6;
    localparam int CODE_LSB   = 0;

    // Raster events in decreasing priority: eof beats eol beats a pixel step
    typedef enum logic [1:0] {
        EV_NONE,
        EV_PIXEL,
        EV_EOL,
        EV_EOF
    } raster_ev_e;

    function automatic int calc_cols(input int screen_w, input int font_w);
        return screen_w / font_w;
    endfunction

    function automatic int calc_rows(input int screen_h, input int font_h);
        return screen_h / font_h;
    endfunction

endpackage

// File: rtl/glyph_raster_cnt.sv
// ---------------------------------------------------------------------------
// glyph_raster_cnt
// Raster position counters for a character-cell display.
//   clk, rst     : clock, synchronous active-high reset
//   px_en        : advance one pixel within the line
//   eol          : end of scan line
//   eof          : end of frame
//   gx, col      : pixel within glyph, character column (saturates at COLS)
//   row          : character row (saturates at ROWS)
//   fi_base      : gy*FONT_W, the glyph bit offset of the current scan line
// gy is kept internally; fi_base is tracked incrementally so no multiplier
// is needed on the pixel path.
// ---------------------------------------------------------------------------
module glyph_raster_cnt
    import txt_pkg::*;
#(
    parameter int FONT_W = DEF_FONT_W,
    parameter int FONT_H = DEF_FONT_H,
    parameter int COLS   = calc_cols(DEF_SCREEN_W, DEF_FONT_W),
    parameter int ROWS   = calc_rows(DEF_SCREEN_H, DEF_FONT_H),
    parameter int GX_W   = $clog2(FONT_W),
    parameter int COL_W  = $clog2(COLS + 1),
    parameter int ROW_W  = $clog2(ROWS + 1),
    parameter int FI_W   = $clog2(FONT_W * FONT_H)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             px_en,
    input  logic             eol,
    input  logic             eof,
    output logic [GX_W-1:0]  gx,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic [FI_W-1:0]  fi_base
);

    localparam int GY_W = $clog2(FONT_H);

    logic [GY_W-1:0] gy;
    raster_ev_e      ev;

    // Collapse the three strobes into a single prioritised event
    always_comb begin
        ev = EV_NONE;
        if (eof) begin
            ev = EV_EOF;
        end else if (eol) begin
            ev = EV_EOL;
        end else if (px_en) begin
            ev = EV_PIXEL;
        end
    end

    // Counter update; col and row stick at their off-screen value until
    // the next eol / eof so overscan pixels are recognisable downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            gx      <= '0;
            col     <= '0;
            gy      <= '0;
            row     <= '0;
            fi_base <= '0;
        end else begin
            case (ev)
                EV_EOF: begin
                    gx      <= '0;
                    col     <= '0;
                    gy      <= '0;
                    row     <= '0;
                    fi_base <= '0;
                end
                EV_EOL: begin
                    gx  <= '0;
                    col <= '0;
                    if (gy == GY_W'(FONT_H - 1)) begin
                        gy      <= '0;
                        fi_base <= '0;
                        if (row < ROW_W'(ROWS)) begin
                            row <= row + ROW_W'(1);
                        end
                    end else begin
                        gy      <= gy + GY_W'(1);
                        fi_base <= fi_base + FI_W'(FONT_W);
                    end
                end
                EV_PIXEL: begin
                    if (gx == GX_W'(FONT_W - 1)) begin
                        gx <= '0;
                        if (col < COL_W'(COLS)) begin
                            col <= col + COL_W'(1);
                        end
                    end else begin
                        gx <= gx + GX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/txt_render_pipe.sv
// ---------------------------------------------------------------------------
// txt_render_pipe
// Text-mode pixel renderer: character memory -> font memory -> pixel.
//   clk, rst               : clock, synchronous active-high reset
//   en                     : render enable (0 forces pxi low only)
//   px_en, eol, eof        : raster timing strobes
//   scroll_row             : top displayed row, sampled on eof
//   cursor_en/col/row      : block cursor, in displayed coordinates
//   char_addr / char_data  : character memory port (1-cycle read)
//   font_addr / font_data  : font memory port (1-cycle read, MSB top-left)
//   pxi, pxi_valid         : pixel out, 3 cycles after its px_en
// ---------------------------------------------------------------------------
module txt_render_pipe
    import txt_pkg::*;
#(
    parameter int FONT_W       = DEF_FONT_W,
    parameter int FONT_H       = DEF_FONT_H,
    parameter int SCREEN_W     = DEF_SCREEN_W,
    parameter int SCREEN_H     = DEF_SCREEN_H,
    parameter int CHAR_W       = DEF_CHAR_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
)(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic                                  px_en,
    input  logic                                  eol,
    input  logic                                  eof,
    input  logic [$clog2(SCREEN_H/FONT_H)-1:0]    scroll_row,
    input  logic                                  cursor_en,
    input  logic [$clog2(SCREEN_W/FONT_W)-1:0]    cursor_col,
    input  logic [$clog2(SCREEN_H/FONT_H)-1:0]    cursor_row,
    output logic [ADDR_W-1:0]                     char_addr,
    input  logic [CHAR_W-1:0]                     char_data,
    output logic [6:0]                            font_addr,
    input  logic [FONT_W*FONT_H-1:0]              font_data,
    output logic                                  pxi,
    output logic                                  pxi_valid
);

    localparam int COLS      = calc_cols(SCREEN_W, FONT_W);
    localparam int ROWS      = calc_rows(SCREEN_H, FONT_H);
    localparam int FONT_BITS = FONT_W * FONT_H;
    localparam int GX_W      = $clog2(FONT_W);
    localparam int COL_W     = $clog2(COLS + 1);
    localparam int ROW_W     = $clog2(ROWS + 1);
    localparam int FI_W      = $clog2(FONT_BITS);
    localparam int SCR_W     = $clog2(ROWS);
    localparam int BLK_W     = $clog2(BLINK_FRAMES + 1);

    logic [GX_W-1:0]  gx;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [FI_W-1:0]  fi_base;

    logic [SCR_W-1:0] scroll_q;
    logic [BLK_W-1:0] blink_cnt;
    logic             phase;

    int               prow_sum;
    logic [FI_W-1:0]  fi0;
    logic             on0;
    logic             hit0;

    logic             v1, on1, hit1;
    logic [FI_W-1:0]  fi1;
    logic             v2, on2, hit2, inv2;
    logic [FI_W-1:0]  fi2;
    logic [FI_W-1:0]  bit_idx;

    glyph_raster_cnt #(
        .FONT_W (FONT_W),
        .FONT_H (FONT_H),
        .COLS   (COLS),
        .ROWS   (ROWS),
        .GX_W   (GX_W),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W),
        .FI_W   (FI_W)
    ) u_raster (
        .clk     (clk),
        .rst     (rst),
        .px_en   (px_en),
        .eol     (eol),
        .eof     (eof),
        .gx      (gx),
        .col     (col),
        .row     (row),
        .fi_base (fi_base)
    );

    // Scroll offset only changes at a frame boundary; out-of-range requests
    // are dropped so the physical row wrap below needs a single subtract
    always_ff @(posedge clk) begin
        if (rst) begin
            scroll_q <= '0;
        end else if (eof && (int'(scroll_row) < ROWS)) begin
            scroll_q <= scroll_row;
        end
    end

    // Cursor blink: phase flips every BLINK_FRAMES frames
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (eof) begin
            if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + BLK_W'(1);
            end
        end
    end

    // Stage 0: address generation and per-pixel attributes from the
    // registered raster state; the cursor compares logical coordinates
    always_comb begin
        prow_sum = int'(row) + int'(scroll_q);
        if (prow_sum >= ROWS) begin
            prow_sum = prow_sum - ROWS;
        end
        char_addr = ADDR_W'(prow_sum * COLS + int'(col));
        fi0       = fi_base + FI_W'(gx);
        on0       = (int'(col) < COLS) && (int'(row) < ROWS);
        hit0      = cursor_en && phase &&
                    (int'(col) == int'(cursor_col)) &&
                    (int'(row) == int'(cursor_row));
    end

    // The glyph code goes straight to the font memory in the cycle after
    // the character read
    assign font_addr = char_data[CODE_MSB:CODE_LSB];
    assign bit_idx   = FI_W'(FONT_BITS - 1) - fi2;

    // Three-stage pipeline matching the two memory read latencies plus the
    // output register
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            fi1       <= '0;
            on1       <= 1'b0;
            hit1      <= 1'b0;
            v2        <= 1'b0;
            fi2       <= '0;
            on2       <= 1'b0;
            hit2      <= 1'b0;
            inv2      <= 1'b0;
            pxi       <= 1'b0;
            pxi_valid <= 1'b0;
        end else begin
            v1        <= px_en;
            fi1       <= fi0;
            on1       <= on0;
            hit1      <= hit0;
            v2        <= v1;
            fi2       <= fi1;
            on2       <= on1;
            hit2      <= hit1;
            inv2      <= char_data[INV_BIT];
            pxi       <= (font_data[bit_idx] ^ inv2 ^ hit2) & on2 & en;
            pxi_valid <= v2;
        end
    end

endmodule

// File: tb/tb_txt_render_pipe.sv
// ---------------------------------------------------------------------------
// tb_txt_render_pipe
// Self-checking bench: memories are modelled as 1-cycle registered reads;
// a behavioural model derives every expected pixel from the pixel/line
// counts since eol/eof, and directed sequences pin literal values.
// ---------------------------------------------------------------------------
module tb_txt_render_pipe;

    localparam int FONT_W       = 15;
    localparam int FONT_H       = 21;
    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int CHAR_W       = 8;
    localparam int ADDR_W       = 13;
    localparam int BLINK_FRAMES = 2;
    localparam int COLS         = SCREEN_W / FONT_W;
    localparam int ROWS         = SCREEN_H / FONT_H;
    localparam int FONT_BITS    = FONT_W * FONT_H;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 en = 1'b0;
    logic                 px_en = 1'b0;
    logic                 eol = 1'b0;
    logic                 eof = 1'b0;
    logic [4:0]           scroll_row = '0;
    logic                 cursor_en = 1'b0;
    logic [5:0]           cursor_col = '0;
    logic [4:0]           cursor_row = '0;
    logic [ADDR_W-1:0]    char_addr;
    logic [CHAR_W-1:0]    char_data;
    logic [6:0]           font_addr;
    logic [FONT_BITS-1:0] font_data;
    logic                 pxi;
    logic                 pxi_valid;

    logic [7:0]           char_mem [0:1023];
    logic [FONT_BITS-1:0] font_mem [0:127];

    typedef struct {
        int   tag;
        logic val;
    } exp_t;

    exp_t exp_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   armed = 1'b0;

    int   m_x = 0;
    int   m_y = 0;
    int   m_scroll = 0;
    int   m_eofs = 0;

    logic       en_req = 1'b1;
    logic       cur_en_req = 1'b0;
    logic [5:0] cur_col_req = '0;
    logic [4:0] cur_row_req = '0;

    logic        obs_pxi;
    logic        obs_valid;
    int          obs_char_addr;
    int          obs_font_addr;

    always #5 clk = ~clk;

    txt_render_pipe #(
        .FONT_W       (FONT_W),
        .FONT_H       (FONT_H),
        .SCREEN_W     (SCREEN_W),
        .SCREEN_H     (SCREEN_H),
        .CHAR_W       (CHAR_W),
        .ADDR_W       (ADDR_W),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .px_en      (px_en),
        .eol        (eol),
        .eof        (eof),
        .scroll_row (scroll_row),
        .cursor_en  (cursor_en),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .char_addr  (char_addr),
        .char_data  (char_data),
        .font_addr  (font_addr),
        .font_data  (font_data),
        .pxi        (pxi),
        .pxi_valid  (pxi_valid)
    );

    // Registered-read memories feeding the DUT
    always @(posedge clk) begin
        char_data <= char_mem[char_addr[9:0]];
        font_data <= font_mem[font_addr];
    end

    // Safety net in case the run never reaches its summary
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: actual timeout, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int model_col();
        return (m_x / FONT_W < COLS) ? (m_x / FONT_W) : COLS;
    endfunction

    function automatic int model_row();
        return (m_y / FONT_H < ROWS) ? (m_y / FONT_H) : ROWS;
    endfunction

    function automatic int model_addr();
        int prow;
        prow = model_row() + m_scroll;
        if (prow >= ROWS) prow = prow - ROWS;
        return prow * COLS + model_col();
    endfunction

    // Expected pixel for a px_en at the current raster position
    function automatic logic model_pixel();
        int                   c, r, fi;
        logic [7:0]           ch;
        logic [FONT_BITS-1:0] glyph;
        logic [8:0]           idx;
        logic                 b, ph, hit, on;
        c     = model_col();
        r     = model_row();
        fi    = (m_y % FONT_H) * FONT_W + (m_x % FONT_W);
        ch    = char_mem[10'(model_addr())];
        glyph = font_mem[ch[6:0]];
        idx   = 9'(FONT_BITS - 1 - fi);
        b     = glyph[idx];
        ph    = ((m_eofs / BLINK_FRAMES) % 2) == 1;
        hit   = cursor_en && ph && (c == int'(cursor_col)) && (r == int'(cursor_row));
        on    = (c < COLS) && (r < ROWS);
        return (b ^ ch[7] ^ hit) & on & en;
    endfunction

    task automatic checkVal(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Per-cycle comparison of the DUT against the model
    task automatic checkOutput();
        exp_t e;
        obs_pxi       = pxi;
        obs_valid     = pxi_valid;
        obs_char_addr = int'(char_addr);
        obs_font_addr = int'(font_addr);
        checkVal("char_addr", obs_char_addr, model_addr());
        if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
            e = exp_q.pop_front();
            checkVal("pxi_valid", int'(pxi_valid), 1);
            checkVal("pxi", int'(pxi), int'(e.val));
        end else begin
            checkVal("pxi_valid_idle", int'(pxi_valid), 0);
        end
    endtask

    // One clock of stimulus: compare first, then drive and advance the model
    task automatic applyStimulus(input logic i_rst, input logic i_px, input logic i_eol,
                                 input logic i_eof, input logic [4:0] i_scroll);
        @(negedge clk);
        cyc++;
        if (armed) checkOutput();
        rst        = i_rst;
        px_en      = i_px;
        eol        = i_eol;
        eof        = i_eof;
        scroll_row = i_scroll;
        en         = en_req;
        cursor_en  = cur_en_req;
        cursor_col = cur_col_req;
        cursor_row = cur_row_req;
        if (i_rst) begin
            exp_q.delete();
            m_x      = 0;
            m_y      = 0;
            m_scroll = 0;
            m_eofs   = 0;
            armed    = 1'b1;
        end else begin
            if (i_px) exp_q.push_back('{tag: cyc + 3, val: model_pixel()});
            if (i_eof) begin
                m_x = 0;
                m_y = 0;
                if (int'(i_scroll) < ROWS) m_scroll = int'(i_scroll);
                m_eofs++;
            end else if (i_eol) begin
                m_x = 0;
                m_y++;
            end else if (i_px) begin
                m_x++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    // eof, three pixels at the top-left glyph, then the three literal results
    task automatic threePixels(input string name, input int e0, input int e1, input int e2);
        int ev[3];
        ev = '{e0, e1, e2};
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
            checkVal({name, "_addr"}, obs_char_addr, 0);
            if (k == 1) checkVal({name, "_font_addr"}, obs_font_addr, 'h41);
        end
        for (int k = 0; k < 3; k++) begin
            idle(1);
            checkVal({name, "_valid"}, int'(obs_valid), 1);
            checkVal({name, "_pxi"}, int'(obs_pxi), ev[k]);
        end
    endtask

    initial begin
        int blink_exp[6];
        logic px, el, ef;
        int mode;
        blink_exp = '{1, 1, 0, 0, 1, 1};

        for (int a = 0; a < 1024; a++) char_mem[a] = 8'($urandom);
        for (int g = 0; g < 128; g++)
            for (int b = 0; b < FONT_BITS; b++)
                font_mem[7'(g)][9'(b)] = 1'($urandom_range(0, 1));
        char_mem[0]            = 8'h41;
        font_mem[7'h41][314]   = 1'b1;
        font_mem[7'h41][313]   = 1'b0;
        font_mem[7'h41][312]   = 1'b1;
        font_mem[7'h7F]        = '1;
        char_mem[42]           = 8'h7F;

        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        idle(1);
        checkVal("reset_valid", int'(obs_valid), 0);
        checkVal("reset_pxi", int'(obs_pxi), 0);
        checkVal("reset_addr", obs_char_addr, 0);

        // Plain and inverse glyph at the top-left cell
        threePixels("glyph41", 1, 0, 1);
        char_mem[0] = 8'hC1;
        threePixels("glyphC1", 0, 1, 0);
        char_mem[0] = 8'h41;

        // Column step after one glyph width, row step after one glyph height
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
            checkVal("col_step_addr", obs_char_addr, (k == 16) ? 1 : 0);
        end
        for (int k = 0; k < 21; k++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        checkVal("row_step_addr", obs_char_addr, 42);
        idle(3);

        // Scroll wrap and rejection of an out-of-range scroll value
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd21);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        checkVal("scroll21_row0", obs_char_addr, 882);
        for (int k = 0; k < 21; k++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        checkVal("scroll21_row1", obs_char_addr, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd25);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        checkVal("scroll25_kept", obs_char_addr, 882);
        idle(3);

        // Overscan column 42 blanks even an all-ones glyph
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        for (int k = 0; k < 631; k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        checkVal("overscan_addr", obs_char_addr, 42);
        idle(3);
        checkVal("overscan_valid", int'(obs_valid), 1);
        checkVal("overscan_pxi", int'(obs_pxi), 0);

        // Reset mid-line discards in-flight pixels
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        for (int k = 0; k < 20; k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        idle(1);
        checkVal("midline_rst_valid", int'(obs_valid), 0);
        checkVal("midline_rst_addr", obs_char_addr, 0);

        // Cursor blink over frames 0..5 with the cursor on cell (0,0)
        cur_en_req  = 1'b1;
        cur_col_req = 6'd0;
        cur_row_req = 5'd0;
        for (int f = 0; f < 6; f++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
            idle(3);
            checkVal("blink_pxi", int'(obs_pxi), blink_exp[f]);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        end
        cur_en_req = 1'b0;
        idle(3);

        // Randomised segments; en only changes while the pipeline is empty
        for (int seg = 0; seg < 40; seg++) begin
            en_req      = ($urandom_range(0, 3) != 0);
            cur_en_req  = 1'($urandom_range(0, 1));
            cur_col_req = 6'($urandom_range(0, 15));
            cur_row_req = 5'($urandom_range(0, 3));
            mode        = int'($urandom_range(0, 2));
            for (int k = 0; k < 500; k++) begin
                px = ($urandom_range(0, 9) < 8);
                case (mode)
                    0:       el = ($urandom_range(0, 99) == 0);
                    1:       el = ($urandom_range(0, 2) == 0);
                    default: el = ($urandom_range(0, 799) == 0);
                endcase
                ef = (mode != 1) && ($urandom_range(0, 599) == 0);
                applyStimulus(($urandom_range(0, 4999) == 0), px, el, ef,
                              5'($urandom_range(0, 31)));
            end
            idle(4);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
